// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared FSM states, strobe levels, RTC register map and phase-length defaults
package rtc_bus_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP, S_STRB, S_HOLD, S_REC} state_t;
    localparam logic STRB_OFF = 1'b1;
    localparam logic [7:0] RTC_SEG = 8'h21;
    localparam logic [7:0] RTC_MIN = 8'h22;
    localparam logic [7:0] RTC_HORA = 8'h23;
    localparam logic [7:0] RTC_CMD = 8'hF0;
    localparam int T_ADDR_DEF = 2;
    localparam int T_GAP_DEF = 1;
    localparam int T_STRB_DEF = 3;
    localparam int T_HOLD_DEF = 1;
    localparam int T_REC_DEF = 2;
endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter that holds at zero and flags it
module rtc_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);
    assign zero = cnt == '0;
    // reload on phase entry, otherwise count down and stick at zero
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: one timed multiplexed-bus cycle on the RTC chip; reads enabled by RTC_BUS_READ_EN
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int T_ADDR = T_ADDR_DEF,
    parameter int T_GAP = T_GAP_DEF,
    parameter int T_STRB = T_STRB_DEF,
    parameter int T_HOLD = T_HOLD_DEF,
    parameter int T_REC = T_REC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n
);
    state_t state, nxt;
    logic load, zero, rd;
    logic [7:0] cnt, load_val, addr_q, wdata_q, addr_v, wdata_v;

    rtc_phase_timer #(.W(8)) u_timer (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_val(load_val),
        .cnt(cnt),
        .zero(zero)
    );

    // phase sequencing; the capture cycle uses the live inputs so outputs can be registered
    always_comb begin
        nxt = state == S_IDLE ? (start ? S_ADDR : S_IDLE) : !zero ? state :
              state == S_REC ? S_IDLE : state_t'(state + 3'd1);
        load = nxt != state;
        load_val = 8'((nxt == S_ADDR ? T_ADDR : nxt == S_GAP ? T_GAP : nxt == S_STRB ? T_STRB :
                       nxt == S_HOLD ? T_HOLD : T_REC) - 1);
        addr_v = state == S_IDLE ? addr : addr_q;
        wdata_v = state == S_IDLE ? wdata : wdata_q;
    end

    // FSM state, captured request and all strobe outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            cs_n <= STRB_OFF;
            wr_n <= STRB_OFF;
            ad_n <= STRB_OFF;
            ad_oe <= 1'b0;
            ad_out <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && start) begin
                addr_q <= addr;
                wdata_q <= wdata;
            end
            cs_n <= nxt == S_IDLE || nxt == S_REC;
            ad_n <= nxt != S_ADDR;
            wr_n <= !(nxt == S_STRB && !rd);
            ad_oe <= nxt == S_ADDR || ((nxt == S_STRB || nxt == S_HOLD) && !rd);
            ad_out <= nxt == S_ADDR ? addr_v : ((nxt == S_STRB || nxt == S_HOLD) && !rd) ? wdata_v : 8'h00;
            busy <= nxt != S_IDLE;
            done <= nxt == S_REC && (load ? T_REC == 1 : cnt == 8'd1);
        end
    end

`ifdef RTC_BUS_READ_EN
    logic rw_q;
    assign rd = state == S_IDLE ? rw : rw_q;
    // read direction, read strobe and bus sample on the final strobe cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q <= 1'b0;
            rd_n <= STRB_OFF;
            rdata <= '0;
        end else begin
            if (state == S_IDLE && start) rw_q <= rw;
            rd_n <= !(nxt == S_STRB && rd);
            rdata <= nxt == S_IDLE ? 8'h00 : (state == S_STRB && zero && rd) ? ad_in : rdata;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{rw, ad_in};
    assign rd = 1'b0;
    assign rd_n = STRB_OFF;
    assign rdata = '0;
`endif
endmodule
